// File: rtl/fir_frame_ctrl_if.sv
// rtl/fir_frame_ctrl_if.sv - sample-in / result-out handshake bundle for fir_frame_ctrl
interface fir_frame_ctrl_if #(
  parameter int WIDTH_X = 8,
  parameter int WIDTH_Y = 18
);
  logic signed [WIDTH_X-1:0] s_data;
  logic                      s_valid;
  logic                      s_ready;
  logic signed [WIDTH_Y-1:0] m_data;
  logic                      m_valid;
  logic                      m_ready;
  logic                      m_last;

  modport master (
    output s_data, s_valid, m_ready,
    input  s_ready, m_data, m_valid, m_last
  );

  modport slave (
    input  s_data, s_valid, m_ready,
    output s_ready, m_data, m_valid, m_last
  );
endinterface

// File: rtl/fir_frame_ctrl.sv
// rtl/fir_frame_ctrl.sv - frames an input stream through a free-running fir_filter
// Each frame is burst into the filter, flushed with N-1 zeros, and its full convolution captured.
module fir_frame_ctrl #(
  parameter int N         = 4,
  parameter int WIDTH_X   = 8,
  parameter int WIDTH_Y   = 18,
  parameter int FRAME_LEN = 16,
  parameter int LAT       = 1,
  parameter int IN_DEPTH  = 32,
  parameter int OUT_DEPTH = 32
) (
  input  logic                      clk,
  input  logic                      rstn,
  fir_frame_ctrl_if.slave           io,
  output logic signed [WIDTH_X-1:0] fir_x,
  input  logic signed [WIDTH_Y-1:0] fir_y,
  output logic                      busy
);

  localparam int IAW     = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
  localparam int ICW     = $clog2(IN_DEPTH + 1);
  localparam int OAW     = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int OCW     = $clog2(OUT_DEPTH + 1);
  localparam int OUT_LEN = FRAME_LEN + N - 1;
  localparam int CW      = $clog2(FRAME_LEN + N + LAT + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_WAIT  = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] cnt;

  // ---------------- input FIFO ----------------
  logic signed [WIDTH_X-1:0] in_mem [IN_DEPTH];
  logic [IAW-1:0]            in_wr, in_rd;
  logic [ICW-1:0]            in_count, in_count_nxt;
  logic                      s_ready_r;
  logic                      in_push, in_pop;

  assign in_push      = io.s_valid && s_ready_r;
  assign in_pop       = (state == ST_RUN);
  assign in_count_nxt = in_count + ICW'(in_push) - ICW'(in_pop);
  assign io.s_ready   = s_ready_r;

  function automatic logic [IAW-1:0] in_inc(input logic [IAW-1:0] p);
    return (p == IAW'(IN_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (in_push) in_mem[in_wr] <= io.s_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      in_wr     <= '0;
      in_rd     <= '0;
      in_count  <= '0;
      s_ready_r <= 1'b0;
    end else begin
      if (in_push) in_wr <= in_inc(in_wr);
      if (in_pop)  in_rd <= in_inc(in_rd);
      in_count  <= in_count_nxt;
      s_ready_r <= in_count_nxt < ICW'(IN_DEPTH);
    end
  end

  // ---------------- output FIFO ----------------
  logic [WIDTH_Y:0] out_mem [OUT_DEPTH];
  logic [OAW-1:0]   out_wr, out_rd;
  logic [OCW-1:0]   out_count, out_free;
  logic             out_push, out_pop;
  logic [LAT:0]     tag_v, tag_l;

  assign out_push = tag_v[LAT];
  assign out_pop  = io.m_valid && io.m_ready;
  assign out_free = OCW'(OUT_DEPTH) - out_count;

  assign io.m_valid = (out_count != '0);
  // Gate with m_valid so the unreset storage never shows through after reset.
  assign io.m_data  = io.m_valid ? out_mem[out_rd][WIDTH_Y-1:0] : '0;
  assign io.m_last  = io.m_valid ? out_mem[out_rd][WIDTH_Y]     : 1'b0;

  function automatic logic [OAW-1:0] out_inc(input logic [OAW-1:0] p);
    return (p == OAW'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (out_push) out_mem[out_wr] <= {tag_l[LAT], fir_y};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_wr    <= '0;
      out_rd    <= '0;
      out_count <= '0;
    end else begin
      if (out_push) out_wr <= out_inc(out_wr);
      if (out_pop)  out_rd <= out_inc(out_rd);
      out_count <= out_count + OCW'(out_push) - OCW'(out_pop);
    end
  end

  // ---------------- sequencer ----------------
  logic start, issue, issue_last;

  // Waiting for an empty capture pipe keeps the space check exact: no write is in flight.
  assign start = (state == ST_IDLE) && (in_count >= ICW'(FRAME_LEN)) &&
                 (out_free >= OCW'(OUT_LEN)) && (tag_v == '0);
  assign issue = (state == ST_RUN) || (state == ST_FLUSH);
  assign issue_last = (N > 1) ? ((state == ST_FLUSH) && (cnt == CW'(N - 2)))
                              : ((state == ST_RUN) && (cnt == CW'(FRAME_LEN - 1)));
  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
      cnt   <= '0;
      fir_x <= '0;
      tag_v <= '0;
      tag_l <= '0;
    end else begin
      fir_x <= (state == ST_RUN) ? in_mem[in_rd] : '0;
      tag_v <= {tag_v[LAT-1:0], issue};
      tag_l <= {tag_l[LAT-1:0], issue_last};
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (start) state <= ST_RUN;
        end
        ST_RUN: begin
          if (cnt == CW'(FRAME_LEN - 1)) begin
            cnt   <= '0;
            state <= (N > 1) ? ST_FLUSH : ST_WAIT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_FLUSH: begin
          if (cnt == CW'(N - 2)) begin
            cnt   <= '0;
            state <= ST_WAIT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          if (cnt == CW'(LAT - 1)) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_frame_ctrl.sv
// tb/tb_fir_frame_ctrl.sv - randomized and directed bench for fir_frame_ctrl with a 4-tap filter
module tb_fir_frame_ctrl;
  localparam int N   = 4;
  localparam int WX  = 8;
  localparam int WY  = 18;
  localparam int FL  = 4;
  localparam int LAT = 1;
  localparam int ID  = 8;
  localparam int OD  = 8;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic signed [WX-1:0] fir_x;
  logic signed [WY-1:0] fir_y;
  logic                 busy;

  fir_frame_ctrl_if #(.WIDTH_X(WX), .WIDTH_Y(WY)) bus ();

  fir_frame_ctrl #(
    .N(N), .WIDTH_X(WX), .WIDTH_Y(WY), .FRAME_LEN(FL),
    .LAT(LAT), .IN_DEPTH(ID), .OUT_DEPTH(OD)
  ) dut (
    .clk(clk), .rstn(rstn), .io(bus.slave),
    .fir_x(fir_x), .fir_y(fir_y), .busy(busy)
  );

  // Free-running 4-tap filter, B={1,2,3,4}, registered output, shares rstn.
  logic signed [WX-1:0] xd1, xd2, xd3;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      xd1 <= '0; xd2 <= '0; xd3 <= '0; fir_y <= '0;
    end else begin
      fir_y <= WY'(1 * fir_x + 2 * xd1 + 3 * xd2 + 4 * xd3);
      xd1 <= fir_x; xd2 <= xd1; xd3 <= xd2;
    end
  end

  int total = 0;
  int bad = 0;
  int rdy_pct = 100;
  int pop_cnt = 0;
  int b_coef[N] = '{1, 2, 3, 4};
  int acc_q[$];
  int exp_d[$];
  bit exp_l[$];

  task automatic check(input string tag, input longint obs, input longint exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: full linear convolution of the frame with B, last flag on the final term.
  task automatic model_frame();
    for (int n = 0; n < FL + N - 1; n++) begin
      int s = 0;
      for (int k = 0; k < N; k++)
        if (n - k >= 0 && n - k < FL) s += b_coef[k] * acc_q[n - k];
      exp_d.push_back(s);
      exp_l.push_back(n == FL + N - 2);
    end
    acc_q.delete();
  endtask

  always @(posedge clk) begin
    #1;
    bus.m_ready = ($urandom_range(99) < rdy_pct);
  end

  logic             hold_v = 1'b0;
  logic [WY:0]      hold_d;
  always @(negedge clk) begin
    if (rstn) begin
      if (hold_v && bus.m_valid) check("stable", {bus.m_last, bus.m_data}, hold_d);
      hold_v = bus.m_valid && !bus.m_ready;
      hold_d = {bus.m_last, bus.m_data};
      if (bus.m_valid && bus.m_ready) begin
        pop_cnt++;
        if (exp_d.size() == 0) check("extra_out", 1, 0);
        else begin
          check("m_data", $signed(bus.m_data), exp_d.pop_front());
          check("m_last", bus.m_last, exp_l.pop_front());
        end
      end
    end else begin
      hold_v = 1'b0;
    end
  end

  task automatic send(input int v, input int gap);
    int n = 0;
    bus.s_data  = WX'(v);
    bus.s_valid = 1'b1;
    @(negedge clk);
    while (!bus.s_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      check("s_ready_timeout", 0, 1);
      bus.s_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
    acc_q.push_back(v);
    if (acc_q.size() == FL) model_frame();
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic send_frame(input int a, input int b, input int c, input int d, input int gap);
    send(a, gap); send(b, gap); send(c, gap); send(d, gap);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((exp_d.size() != 0 || busy) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(tag, n < 3000, 1);
    check({tag, "_left"}, exp_d.size(), 0);
  endtask

  task automatic pop_exact(input int cnt);
    int target = pop_cnt + cnt;
    int n = 0;
    rdy_pct = 100;
    while (pop_cnt < target && n < 200) begin
      @(posedge clk);
      n++;
    end
    rdy_pct = 0;
    check("pop_timeout", n < 200, 1);
  endtask

  initial begin
    int n;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b0;
    #3;
    check("rst_s_ready", bus.s_ready, 0);
    check("rst_m_valid", bus.m_valid, 0);
    check("rst_m_last", bus.m_last, 0);
    check("rst_m_data", bus.m_data, 0);
    check("rst_busy", busy, 0);
    check("rst_fir_x", fir_x, 0);
    #9 rstn = 1'b1;
    #2 check("s_ready_lag", bus.s_ready, 0);
    #2 check("s_ready_up", bus.s_ready, 1);

    // impulse, back-to-back with no tail leakage, signed extremes
    send_frame(1, 0, 0, 0, 0);
    wait_drain("impulse");
    send_frame(127, 127, 127, 127, 0);
    send_frame(1, 0, 0, 0, 0);
    wait_drain("back2back");
    send_frame(-128, 0, 0, -1, 0);
    wait_drain("signed");

    // gapped input: nothing starts before the 4th accept
    send(1, 1); send(0, 1); send(0, 1);
    repeat (3) begin @(posedge clk); #1; end
    check("run_early", busy, 0);
    send(0, 1);
    wait_drain("gapped");

    // backpressure: second frame waits until enough output space frees up
    rdy_pct = 0;
    repeat (2) begin @(posedge clk); #1; end
    send_frame(127, 127, 127, 127, 0);
    send_frame(1, 0, 0, 0, 0);
    repeat (40) begin @(posedge clk); #1; end
    check("bp_busy", busy, 0);
    check("bp_valid", bus.m_valid, 1);
    pop_exact(5);
    repeat (10) begin @(posedge clk); #1; end
    check("q2_hold", busy, 0);
    pop_exact(1);
    n = 0;
    while (!busy && n < 8) begin @(posedge clk); #1; n++; end
    check("q2_start", busy, 1);
    rdy_pct = 100;
    wait_drain("backpressure");

    // reset on the second RUN cycle discards the partial frame
    send_frame(1, 0, 0, 0, 0);
    n = 0;
    while (!busy && n < 50) begin @(posedge clk); #1; n++; end
    check("run_seen", busy, 1);
    @(posedge clk);
    #1 rstn = 1'b0;
    #2;
    check("mid_fir_x", fir_x, 0);
    check("mid_busy", busy, 0);
    check("mid_s_ready", bus.s_ready, 0);
    check("mid_m_valid", bus.m_valid, 0);
    check("mid_m_data", bus.m_data, 0);
    check("mid_m_last", bus.m_last, 0);
    exp_d.delete();
    exp_l.delete();
    acc_q.delete();
    #1 rstn = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check("post_rst_empty", bus.m_valid, 0);
    send_frame(1, 0, 0, 0, 0);
    wait_drain("after_reset");

    // random frames with random gaps and random backpressure
    rdy_pct = 60;
    for (int f = 0; f < 24; f++)
      for (int i = 0; i < FL; i++)
        send(int'($urandom_range(255)) - 128, int'($urandom_range(2)));
    wait_drain("random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
